// File: rtl/op2_pkg.sv
// rtl/op2_pkg.sv - shared constants and helpers for the ALU second-operand stage
//
// Contents:
//   OP2_* : 3-bit source-select encodings
//   OP2_RA_W : default register-index width
//   clog2 : ceiling log2, used to size the HI/LO busy counter

package op2_pkg;

  localparam logic [2:0] OP2_PB   = 3'b000;  // pb after forwarding
  localparam logic [2:0] OP2_HI   = 3'b001;
  localparam logic [2:0] OP2_LO   = 3'b010;
  localparam logic [2:0] OP2_PC   = 3'b011;
  localparam logic [2:0] OP2_SEXT = 3'b100;  // imm sign-extended
  localparam logic [2:0] OP2_ZEXT = 3'b101;  // imm zero-extended
  localparam logic [2:0] OP2_LUI  = 3'b110;  // imm in the upper bits
  localparam logic [2:0] OP2_ZERO = 3'b111;

  localparam int OP2_RA_W = 5;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/op2_fwd_mux.sv
// rtl/op2_fwd_mux.sv - priority forwarding of operand B from later pipeline stages
//
// Ports:
//   src_reg   in  RA_W      register index of pb
//   pb        in  W         register-file value
//   fwd_valid in  NFWD      per-source valid
//   fwd_reg   in  NFWD*RA_W per-source destination index, source k in slice k
//   fwd_data  in  NFWD*W    per-source data, source k in slice k
//   pb_fwd    out W         forwarded operand (0 when src_reg is register 0)

module op2_fwd_mux #(
  parameter int W    = 32,
  parameter int RA_W = 5,
  parameter int NFWD = 2
) (
  input  logic [RA_W-1:0]      src_reg,
  input  logic [W-1:0]         pb,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RA_W-1:0] fwd_reg,
  input  logic [NFWD*W-1:0]    fwd_data,
  output logic [W-1:0]         pb_fwd
);

  always_comb begin
    pb_fwd = pb;
    // Walk oldest to youngest so the lowest matching index is written last and wins.
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_valid[k] && (fwd_reg[k*RA_W +: RA_W] == src_reg)) begin
        pb_fwd = fwd_data[k*W +: W];
      end
    end
    // Register 0 is hardwired to zero; a stage "writing" it must not leak through.
    if (src_reg == '0) begin
      pb_fwd = '0;
    end
  end

endmodule

// File: rtl/operand2_stage.sv
// rtl/operand2_stage.sv - registered ALU second-operand select with forwarding and HI/LO interlock
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   sel                 source select (op2_pkg OP2_*)
//   pb, src_reg         register operand B and its index
//   hi, lo, pc, imm     alternative operand sources
//   fwd_valid/reg/data  NFWD forwarding sources, index 0 youngest
//   hilo_start          multiply/divide issued this cycle
//   flush               kill output register contents
//   out_valid/out_ready output handshake
//   n_out               registered operand
//   hilo_busy           HI/LO results not yet available

module operand2_stage
  import op2_pkg::*;
#(
  parameter int W        = 32,
  parameter int IMM_W    = 16,
  parameter int RA_W     = OP2_RA_W,
  parameter int NFWD     = 2,
  parameter int HILO_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           sel,
  input  logic [W-1:0]         pb,
  input  logic [RA_W-1:0]      src_reg,
  input  logic [W-1:0]         hi,
  input  logic [W-1:0]         lo,
  input  logic [W-1:0]         pc,
  input  logic [IMM_W-1:0]     imm,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RA_W-1:0] fwd_reg,
  input  logic [NFWD*W-1:0]    fwd_data,
  input  logic                 hilo_start,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         n_out,
  output logic                 hilo_busy
);

  localparam int CNT_W = clog2(HILO_LAT + 1);

  logic [CNT_W-1:0] busy_cnt;
  logic [W-1:0]     pb_fwd;
  logic [W-1:0]     operand;
  logic             sel_hilo;
  logic             hazard;
  logic             accept;

  op2_fwd_mux #(
    .W    (W),
    .RA_W (RA_W),
    .NFWD (NFWD)
  ) u_fwd_mux (
    .src_reg   (src_reg),
    .pb        (pb),
    .fwd_valid (fwd_valid),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data),
    .pb_fwd    (pb_fwd)
  );

  assign hilo_busy = (busy_cnt != '0);
  assign sel_hilo  = (sel == OP2_HI) || (sel == OP2_LO);
  assign hazard    = in_valid && sel_hilo && hilo_busy;
  assign in_ready  = (!out_valid || out_ready) && !hazard && !flush;
  assign accept    = in_valid && in_ready;

  always_comb begin
    operand = '0;
    case (sel)
      OP2_PB:   operand = pb_fwd;
      OP2_HI:   operand = hi;
      OP2_LO:   operand = lo;
      OP2_PC:   operand = pc;
      OP2_SEXT: operand = {{(W-IMM_W){imm[IMM_W-1]}}, imm};
      OP2_ZEXT: operand = {{(W-IMM_W){1'b0}}, imm};
      OP2_LUI:  operand = {imm, {(W-IMM_W){1'b0}}};
      default:  operand = '0;
    endcase
  end

  // Busy counter: the hazard above samples the pre-edge value, so a HI/LO
  // request issued alongside hilo_start with an idle counter still goes through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (hilo_start) begin
      busy_cnt <= CNT_W'(HILO_LAT);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      n_out     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      n_out     <= operand;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand2_stage.sv
// tb/tb_operand2_stage.sv - directed self-checking bench for operand2_stage

module tb_operand2_stage;

  localparam int W    = 32;
  localparam int RA_W = 5;
  localparam int NFWD = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      sel;
  logic [W-1:0]    pb;
  logic [RA_W-1:0] src_reg;
  logic [W-1:0]    hi;
  logic [W-1:0]    lo;
  logic [W-1:0]    pc;
  logic [15:0]     imm;
  logic [NFWD-1:0] fwd_valid;
  logic [NFWD*RA_W-1:0] fwd_reg;
  logic [NFWD*W-1:0]    fwd_data;
  logic            hilo_start;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    n_out;
  logic            hilo_busy;

  int n_checks = 0;
  int n_errors = 0;

  operand2_stage #(
    .W(W), .IMM_W(16), .RA_W(RA_W), .NFWD(NFWD), .HILO_LAT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .pb(pb), .src_reg(src_reg), .hi(hi), .lo(lo), .pc(pc),
    .imm(imm), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .hilo_start(hilo_start), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .n_out(n_out), .hilo_busy(hilo_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [2:0]      sel;
    logic [RA_W-1:0] src_reg;
    logic [1:0]      fv;
    logic [RA_W-1:0] r0;
    logic [W-1:0]    d0;
    logic [RA_W-1:0] r1;
    logic [W-1:0]    d1;
    logic [W-1:0]    exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{3'b000, 5'd1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'h12345678};
    vecs[1]  = '{3'b001, 5'd1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'h87654321};
    vecs[2]  = '{3'b010, 5'd1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'hABCDEFAB};
    vecs[3]  = '{3'b011, 5'd1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'hFEDCBA98};
    vecs[4]  = '{3'b100, 5'd1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'hFFFF8001};
    vecs[5]  = '{3'b101, 5'd1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'h00008001};
    vecs[6]  = '{3'b110, 5'd1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'h80010000};
    vecs[7]  = '{3'b111, 5'd1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'h00000000};
    vecs[8]  = '{3'b000, 5'd5, 2'b11, 5'd5, 32'hAAAA0000, 5'd5, 32'hBBBB0000, 32'hAAAA0000};
    vecs[9]  = '{3'b000, 5'd5, 2'b10, 5'd5, 32'hAAAA0000, 5'd5, 32'hBBBB0000, 32'hBBBB0000};
    vecs[10] = '{3'b000, 5'd0, 2'b01, 5'd0, 32'h0000FFFF, 5'd0, 32'h0, 32'h00000000};
    vecs[11] = '{3'b000, 5'd5, 2'b11, 5'd3, 32'hAAAA0000, 5'd7, 32'hBBBB0000, 32'h12345678};

    rst_n = 1'b0; in_valid = 1'b0; sel = 3'b000; pb = 32'h12345678; src_reg = 5'd1;
    hi = 32'h87654321; lo = 32'hABCDEFAB; pc = 32'hFEDCBA98; imm = 16'h8001;
    fwd_valid = '0; fwd_reg = '0; fwd_data = '0; hilo_start = 1'b0; flush = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_out_valid", W'(out_valid), 32'd0);
    check("reset_n_out", n_out, 32'd0);
    check("reset_hilo_busy", W'(hilo_busy), 32'd0);
    rst_n = 1'b1;
    #1 check("idle_in_ready", W'(in_ready), 32'd1);

    // Table: one accept per cycle with out_ready=1
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1; sel = vecs[i].sel; src_reg = vecs[i].src_reg;
      fwd_valid = vecs[i].fv; fwd_reg = {vecs[i].r1, vecs[i].r0};
      fwd_data = {vecs[i].d1, vecs[i].d0};
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), W'(out_valid), 32'd1);
      check($sformatf("vec%0d_n_out", i), n_out, vecs[i].exp);
    end
    @(negedge clk);
    in_valid = 1'b0; fwd_valid = '0; src_reg = 5'd1;

    // HI stall: hilo_start at t, HI request from t+1, stalled t+1..t+4
    @(negedge clk); hilo_start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      hilo_start = 1'b0; in_valid = 1'b1; sel = 3'b001; hi = 32'hCAFE0000 + i;
      #1 check($sformatf("hilo_stall_ready_t%0d", i), W'(in_ready), (i == 5) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    check("hilo_capture_valid", W'(out_valid), 32'd1);
    check("hilo_capture_value", n_out, 32'hCAFE0005);

    // Non-HI/LO select proceeds while busy
    @(negedge clk); in_valid = 1'b0; hilo_start = 1'b1;
    @(negedge clk); hilo_start = 1'b0; in_valid = 1'b1; sel = 3'b011;
    #1 check("pc_while_busy_ready", W'(in_ready), 32'd1);
    check("pc_while_busy_busy", W'(hilo_busy), 32'd1);
    @(posedge clk); #1 check("pc_while_busy_n_out", n_out, 32'hFEDCBA98);
    @(negedge clk); in_valid = 1'b0;
    repeat (5) @(negedge clk);

    // hilo_start with an idle counter does not block a same-cycle LO request
    hilo_start = 1'b1; in_valid = 1'b1; sel = 3'b010;
    #1 check("start_same_cycle_ready", W'(in_ready), 32'd1);
    @(posedge clk); #1 check("start_same_cycle_n_out", n_out, 32'hABCDEFAB);
    @(negedge clk); hilo_start = 1'b0; in_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Busy restart: starts at t and t+2; busy through t+6, clear at t+7
    hilo_start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      hilo_start = (i == 2);
      #1 check($sformatf("restart_busy_t%0d", i), W'(hilo_busy), (i <= 6) ? 32'd1 : 32'd0);
    end
    @(negedge clk); hilo_start = 1'b0;

    // Backpressure
    in_valid = 1'b1; sel = 3'b011; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; sel = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_ready_%0d", i), W'(in_ready), 32'd0);
      check($sformatf("bp_valid_%0d", i), W'(out_valid), 32'd1);
      check($sformatf("bp_n_out_%0d", i), n_out, 32'hFEDCBA98);
      @(negedge clk);
    end
    out_ready = 1'b1; sel = 3'b101;
    #1 check("bp_release_ready", W'(in_ready), 32'd1);
    @(negedge clk);
    check("b2b_first_valid", W'(out_valid), 32'd1);
    check("b2b_first_n_out", n_out, 32'h00008001);
    sel = 3'b100;
    @(negedge clk);
    check("b2b_second_valid", W'(out_valid), 32'd1);
    check("b2b_second_n_out", n_out, 32'hFFFF8001);

    // Flush with a pending request: no capture, output dropped
    flush = 1'b1; sel = 3'b111; out_ready = 1'b0;
    #1 check("flush_ready", W'(in_ready), 32'd0);
    @(negedge clk);
    check("flush_valid", W'(out_valid), 32'd0);
    check("flush_n_out_hold", n_out, 32'hFFFF8001);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);

    // Asynchronous reset with output valid and counter at 3
    hilo_start = 1'b1; in_valid = 1'b1; sel = 3'b011; out_ready = 1'b0;
    @(negedge clk); hilo_start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_reset_valid", W'(out_valid), 32'd1);
    check("pre_reset_busy", W'(hilo_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", W'(out_valid), 32'd0);
    check("async_reset_n_out", n_out, 32'd0);
    check("async_reset_busy", W'(hilo_busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
